// File: rtl/wb_intc.sv
// Wishbone interrupt controller: NUM_IRQ prioritised maskable channels plus an edge NMI.
// Registered ack one cycle after strobe; INTA vector latched on the rising edge of inta_i.
module wb_intc #(
    parameter int          NUM_IRQ     = 4,
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  VEC_BASE    = 8'h0C,
    parameter logic [7:0]  NMI_VEC     = 8'h02
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_stb_i,
    input  logic               wb_cyc_i,
    input  logic               wb_we_i,
    input  logic [2:0]         wb_adr_i,
    input  logic [1:0]         wb_sel_i,
    input  logic [15:0]        wb_dat_i,
    output logic [15:0]        wb_dat_o,
    output logic               wb_ack_o,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               nmi_i,
    output logic               intr_o,
    input  logic               inta_i,
    output logic               nmi_o,
    input  logic               nmia_i,
    output logic [7:0]         vec_o
);

    typedef enum logic {IDLE, ACK} state_t;

    state_t                              state_q, state_d;
    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] irq_sync_q;
    logic [NUM_IRQ-1:0]                  irq_prev_q;
    logic [SYNC_STAGES-1:0]              nmi_sync_q;
    logic                                nmi_prev_q;
    logic                                inta_prev_q;
    logic                                nmia_prev_q;
    logic [NUM_IRQ-1:0]                  mask_q, mask_d;
    logic [NUM_IRQ-1:0]                  mode_q, mode_d;
    logic [NUM_IRQ-1:0]                  pend_q, pend_d;
    logic [NUM_IRQ-1:0]                  isr_q, isr_d;
    logic [7:0]                          vec_q, vec_d;
    logic                                nmi_q, nmi_d;
    logic                                intr_q, intr_d;
    logic                                ack_q, ack_d;
    logic [15:0]                         dat_q, dat_d;

    logic [NUM_IRQ-1:0] irq_s, irq_edge, elig, take_oh, eoi_clr;
    logic               nmi_s, nmi_edge, nmia_rise, inta_rise;
    logic               top_vld, blocked;
    logic [2:0]         top_idx;
    logic               acc, wr;
    logic [15:0]        rdata;
    logic               unused_bits;

    assign unused_bits = ^{wb_dat_i[15:8], wb_sel_i[1]};

    assign irq_s     = irq_sync_q[SYNC_STAGES-1];
    assign irq_edge  = irq_s & ~irq_prev_q;
    assign nmi_s     = nmi_sync_q[SYNC_STAGES-1];
    assign nmi_edge  = nmi_s & ~nmi_prev_q;
    assign nmia_rise = nmia_i & ~nmia_prev_q;
    assign acc       = wb_stb_i & wb_cyc_i & ~ack_q;
    assign wr        = acc & wb_we_i & wb_sel_i[0];

    // Fully nested: any in-service bit at or above a channel's priority blocks it.
    // top_idx defaults to 7 so a spurious INTA naturally latches VEC_BASE+7.
    always_comb begin
        elig    = '0;
        blocked = 1'b0;
        for (int n = 0; n < NUM_IRQ; n++) begin
            blocked = blocked | isr_q[n];
            elig[n] = pend_q[n] & ~mask_q[n] & ~blocked;
        end
        top_vld = 1'b0;
        top_idx = 3'd7;
        for (int n = NUM_IRQ - 1; n >= 0; n--) begin
            if (elig[n]) begin
                top_vld = 1'b1;
                top_idx = 3'(n);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        inta_rise = 1'b0;
        case (state_q)
            IDLE: begin
                if (inta_i && !inta_prev_q) begin
                    inta_rise = 1'b1;
                    state_d   = ACK;
                end
            end
            ACK: begin
                if (!inta_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        take_oh = '0;
        if (inta_rise && top_vld) take_oh = NUM_IRQ'(1) << top_idx;

        eoi_clr = '0;
        if (wr && wb_adr_i == 3'd0) begin
            if (wb_dat_i[7])
                eoi_clr = isr_q & (~isr_q + NUM_IRQ'(1));
            else if (int'(wb_dat_i[2:0]) < NUM_IRQ)
                eoi_clr = NUM_IRQ'(1) << wb_dat_i[2:0];
        end

        mask_d = mask_q;
        mode_d = mode_q;
        if (wr && wb_adr_i == 3'd1) mask_d = wb_dat_i[NUM_IRQ-1:0];
        if (wr && wb_adr_i == 3'd2) mode_d = wb_dat_i[NUM_IRQ-1:0];

        // Edge channels: a new edge beats a same-cycle acknowledge clear.
        pend_d = (mode_q & irq_s) | (~mode_q & ((pend_q & ~take_oh) | irq_edge));
        isr_d  = (isr_q & ~eoi_clr) | take_oh;
        vec_d  = inta_rise ? (VEC_BASE + {5'b0, top_idx}) : vec_q;
        intr_d = top_vld & (state_q != ACK);
        nmi_d  = nmi_edge | (nmi_q & ~nmia_rise);
        ack_d  = acc;
    end

    always_comb begin
        rdata = '0;
        case (wb_adr_i)
            3'd1:    rdata = 16'(mask_q);
            3'd2:    rdata = 16'(mode_q);
            3'd3:    rdata = 16'(pend_q);
            3'd4:    rdata = 16'(isr_q);
            3'd5:    rdata = {9'b0, top_idx, 2'b0, nmi_q, intr_q};
            default: rdata = '0;
        endcase
        dat_d = (acc && !wb_we_i) ? rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            irq_sync_q  <= '0;
            irq_prev_q  <= '0;
            nmi_sync_q  <= '0;
            nmi_prev_q  <= 1'b0;
            inta_prev_q <= 1'b0;
            nmia_prev_q <= 1'b0;
            mask_q      <= '1;
            mode_q      <= '0;
            pend_q      <= '0;
            isr_q       <= '0;
            vec_q       <= '0;
            nmi_q       <= 1'b0;
            intr_q      <= 1'b0;
            ack_q       <= 1'b0;
            dat_q       <= '0;
        end else begin
            state_q     <= state_d;
            irq_sync_q  <= {irq_sync_q[SYNC_STAGES-2:0], irq_i};
            irq_prev_q  <= irq_s;
            nmi_sync_q  <= {nmi_sync_q[SYNC_STAGES-2:0], nmi_i};
            nmi_prev_q  <= nmi_s;
            inta_prev_q <= inta_i;
            nmia_prev_q <= nmia_i;
            mask_q      <= mask_d;
            mode_q      <= mode_d;
            pend_q      <= pend_d;
            isr_q       <= isr_d;
            vec_q       <= vec_d;
            nmi_q       <= nmi_d;
            intr_q      <= intr_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign intr_o   = intr_q;
    assign nmi_o    = nmi_q;
    assign vec_o    = nmia_i ? NMI_VEC : (inta_i ? vec_q : 8'h00);

endmodule

// File: tb/tb_wb_intc.sv
// Bench for wb_intc: register table plus interrupt/NMI/reset sequences, reads scored via a queue.
module tb_wb_intc;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_stb_i, wb_cyc_i, wb_we_i;
    logic [2:0]  wb_adr_i;
    logic [1:0]  wb_sel_i;
    logic [15:0] wb_dat_i, wb_dat_o;
    logic        wb_ack_o;
    logic [3:0]  irq_i;
    logic        nmi_i, intr_o, inta_i, nmi_o, nmia_i;
    logic [7:0]  vec_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          rd;
        logic [15:0] exp;
        string       name;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        bit          we;
        logic [2:0]  adr;
        logic [1:0]  sel;
        logic [15:0] dat;
        logic [15:0] exp;
        string       name;
    } wbv_t;

    wb_intc #(.NUM_IRQ(4), .SYNC_STAGES(SYNC), .VEC_BASE(8'h0C), .NMI_VEC(8'h02)) dut (
        .clk(clk), .rst(rst),
        .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .irq_i(irq_i), .nmi_i(nmi_i), .intr_o(intr_o), .inta_i(inta_i),
        .nmi_o(nmi_o), .nmia_i(nmia_i), .vec_o(vec_o)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [15:0] act, logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Every ack consumes one scoreboard entry; reads compare the returned data.
    always @(negedge clk) begin
        if (wb_ack_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("spurious_ack", 16'd1, 16'd0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                if (e.rd) chk(e.name, wb_dat_o, e.exp);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb(input bit we, input logic [2:0] adr, input logic [15:0] dat,
                      input logic [15:0] exp, input string name, input logic [1:0] sel = 2'b01);
        sb_t e;
        e.rd = !we; e.exp = exp; e.name = name;
        sb_q.push_back(e);
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr;  wb_sel_i = sel;  wb_dat_i = dat;
        tick(1);
        chk({name, "_ack_lat"}, 16'(wb_ack_o), 16'd1);
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        tick(1);
        chk({name, "_ack_once"}, 16'(wb_ack_o), 16'd0);
    endtask

    task automatic pulse_irq(input int i);
        irq_i[i] = 1'b1;
        tick(1);
        irq_i[i] = 1'b0;
        tick(SYNC + 1);
    endtask

    task automatic pulse_nmi();
        nmi_i = 1'b1;
        tick(1);
        nmi_i = 1'b0;
        tick(SYNC + 1);
    endtask

    task automatic do_inta(input logic [7:0] exp_vec, input string name);
        inta_i = 1'b1;
        tick(1);
        chk({name, "_vec"}, 16'(vec_o), 16'(exp_vec));
        tick(1);
        chk({name, "_intr_busy"}, 16'(intr_o), 16'd0);
        inta_i = 1'b0;
        tick(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wbv_t tv[$];
        tv = '{
            '{0, 3'd1, 2'b01, 16'h0000, 16'h000F, "rst_mask"},
            '{0, 3'd2, 2'b01, 16'h0000, 16'h0000, "rst_mode"},
            '{0, 3'd3, 2'b01, 16'h0000, 16'h0000, "rst_pend"},
            '{0, 3'd4, 2'b01, 16'h0000, 16'h0000, "rst_isr"},
            '{0, 3'd0, 2'b01, 16'h0000, 16'h0000, "rd_eoi"},
            '{0, 3'd6, 2'b01, 16'h0000, 16'h0000, "rd_r6"},
            '{0, 3'd7, 2'b01, 16'h0000, 16'h0000, "rd_r7"},
            '{1, 3'd1, 2'b01, 16'h00A5, 16'h0000, "wr_mask"},
            '{0, 3'd1, 2'b01, 16'h0000, 16'h0005, "mask_lowbits"},
            '{1, 3'd1, 2'b10, 16'h0000, 16'h0000, "wr_mask_hisel"},
            '{0, 3'd1, 2'b01, 16'h0000, 16'h0005, "mask_sel_ignored"},
            '{1, 3'd2, 2'b01, 16'hFFFF, 16'h0000, "wr_mode"},
            '{0, 3'd2, 2'b01, 16'h0000, 16'h000F, "mode_width"},
            '{1, 3'd2, 2'b01, 16'h0000, 16'h0000, "wr_mode0"},
            '{0, 3'd2, 2'b01, 16'h0000, 16'h0000, "mode_clear"},
            '{1, 3'd6, 2'b01, 16'h00FF, 16'h0000, "wr_r6"},
            '{0, 3'd6, 2'b01, 16'h0000, 16'h0000, "r6_ignored"},
            '{1, 3'd1, 2'b01, 16'h0000, 16'h0000, "wr_mask0"},
            '{0, 3'd1, 2'b01, 16'h0000, 16'h0000, "mask_open"}
        };

        rst = 1'b1;
        wb_stb_i = 0; wb_cyc_i = 0; wb_we_i = 0; wb_adr_i = '0; wb_sel_i = '0; wb_dat_i = '0;
        irq_i = '0; nmi_i = 0; inta_i = 0; nmia_i = 0;
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("rst_intr", 16'(intr_o), 16'd0);
        chk("rst_nmi", 16'(nmi_o), 16'd0);
        chk("rst_vec", 16'(vec_o), 16'd0);

        foreach (tv[i]) wb(tv[i].we, tv[i].adr, tv[i].dat, tv[i].exp, tv[i].name, tv[i].sel);

        // Single edge channel through INTA
        pulse_irq(2);
        chk("irq2_intr", 16'(intr_o), 16'd1);
        wb(0, 3'd3, 16'h0, 16'h0004, "irq2_pend");
        do_inta(8'h0E, "inta2");
        wb(0, 3'd4, 16'h0, 16'h0004, "inta2_isr");
        wb(0, 3'd3, 16'h0, 16'h0000, "inta2_pend");

        // Nesting and non-specific EOI
        pulse_irq(3);
        chk("irq3_blocked", 16'(intr_o), 16'd0);
        pulse_irq(1);
        chk("irq1_preempt", 16'(intr_o), 16'd1);
        do_inta(8'h0D, "inta1");
        wb(0, 3'd4, 16'h0, 16'h0006, "nest_isr");
        wb(0, 3'd3, 16'h0, 16'h0008, "nest_pend");
        wb(1, 3'd0, 16'h0080, 16'h0, "eoi_ns1");
        wb(0, 3'd4, 16'h0, 16'h0004, "eoi_ns1_isr");
        chk("ch3_still_blocked", 16'(intr_o), 16'd0);
        wb(1, 3'd0, 16'h0080, 16'h0, "eoi_ns2");
        chk("ch3_released", 16'(intr_o), 16'd1);
        wb(0, 3'd4, 16'h0, 16'h0000, "eoi_ns2_isr");
        wb(0, 3'd5, 16'h0, 16'h0031, "status_ch3");
        do_inta(8'h0F, "inta3");
        wb(1, 3'd0, 16'h0005, 16'h0, "eoi_badidx");
        wb(0, 3'd4, 16'h0, 16'h0008, "eoi_badidx_isr");
        wb(1, 3'd0, 16'h0003, 16'h0, "eoi_spec3");
        wb(0, 3'd4, 16'h0, 16'h0000, "eoi_spec3_isr");

        // Level mode persists through acknowledge
        wb(1, 3'd2, 16'h0001, 16'h0, "wr_mode_lvl");
        irq_i[0] = 1'b1;
        tick(SYNC + 2);
        chk("lvl_intr", 16'(intr_o), 16'd1);
        do_inta(8'h0C, "inta0_lvl");
        wb(0, 3'd3, 16'h0, 16'h0001, "lvl_pend_kept");
        wb(0, 3'd4, 16'h0, 16'h0001, "lvl_isr");
        wb(1, 3'd0, 16'h0000, 16'h0, "eoi_spec0");
        chk("lvl_reassert", 16'(intr_o), 16'd1);
        irq_i[0] = 1'b0;
        tick(SYNC + 2);
        chk("lvl_drop_intr", 16'(intr_o), 16'd0);
        wb(0, 3'd3, 16'h0, 16'h0000, "lvl_drop_pend");
        wb(1, 3'd2, 16'h0000, 16'h0, "wr_mode_edge");

        // Spurious INTA
        do_inta(8'h13, "spurious");
        wb(0, 3'd4, 16'h0, 16'h0000, "spurious_isr");

        // NMI set/clear, vector precedence, coincident edge and clear
        pulse_nmi();
        chk("nmi_set", 16'(nmi_o), 16'd1);
        nmia_i = 1'b1; inta_i = 1'b1;
        tick(1);
        chk("nmia_vec", 16'(vec_o), 16'h0002);
        chk("nmia_clr", 16'(nmi_o), 16'd0);
        nmia_i = 1'b0;
        #1;
        chk("inta_after_nmia_vec", 16'(vec_o), 16'h0013);
        inta_i = 1'b0;
        #1;
        chk("idle_vec", 16'(vec_o), 16'h0000);
        tick(1);
        pulse_nmi();
        chk("nmi_set2", 16'(nmi_o), 16'd1);
        nmi_i = 1'b1;
        tick(1);
        nmi_i = 1'b0;
        tick(SYNC - 1);
        nmia_i = 1'b1;
        tick(1);
        chk("nmi_coincide", 16'(nmi_o), 16'd1);
        nmia_i = 1'b0;
        tick(1);
        nmia_i = 1'b1;
        tick(1);
        chk("nmi_clr2", 16'(nmi_o), 16'd0);
        nmia_i = 1'b0;
        tick(1);

        // Reset in the middle of an INTA with state pending
        pulse_irq(0);
        inta_i = 1'b1;
        tick(1);
        chk("pre_rst_vec", 16'(vec_o), 16'h000C);
        pulse_irq(1);
        wb(0, 3'd4, 16'h0, 16'h0001, "pre_rst_isr");
        wb(0, 3'd3, 16'h0, 16'h0002, "pre_rst_pend");
        pulse_nmi();
        rst = 1'b1;
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 3'd1;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk("rst_no_ack", 16'(wb_ack_o), 16'd0);
        end
        chk("mid_rst_intr", 16'(intr_o), 16'd0);
        chk("mid_rst_nmi", 16'(nmi_o), 16'd0);
        chk("mid_rst_vec", 16'(vec_o), 16'd0);
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; inta_i = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(1);
        wb(0, 3'd1, 16'h0, 16'h000F, "post_rst_mask");
        wb(0, 3'd2, 16'h0, 16'h0000, "post_rst_mode");
        wb(0, 3'd3, 16'h0, 16'h0000, "post_rst_pend");
        wb(0, 3'd4, 16'h0, 16'h0000, "post_rst_isr");
        chk("post_rst_intr", 16'(intr_o), 16'd0);

        tick(2);
        chk("sb_drained", 16'(sb_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_intc.md
Name: wb_intc

Overview:
- Parametrised Wishbone interrupt controller for the 80186 co-processor SoC.
- Replaces the fixed tube IRQ/NMI synchronisers and the hard-wired INTA vector logic in the top level.
- Provides NUM_IRQ prioritised channels with per-channel mask and edge/level mode, in-service tracking, EOI, and a separate edge-triggered NMI.
- Sits on the Wishbone switch slave 2 (I/O 0xFF20-0xFF2E); drives zet wb_tgc_i/nmi and supplies the vector muxed onto dat_i during inta/nmia.

Parameters:
NUM_IRQ, 4, number of maskable channels (1..8); channel 0 is highest priority.
SYNC_STAGES, 2, flip-flop stages on each asynchronous input (2..4).
VEC_BASE, 8'h0C, vector returned for channel n is VEC_BASE+n (8-bit, wraps modulo 256).
NMI_VEC, 8'h02, vector returned while nmia_i is high.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
wb_stb_i  in  1  Wishbone strobe
wb_cyc_i  in  1  Wishbone cycle
wb_we_i  in  1  write enable
wb_adr_i  in  3  register index (CPU address bits 3:1)
wb_sel_i  in  2  byte selects; only sel[0] (low byte) writes registers
wb_dat_i  in  16  write data
wb_dat_o  out  16  read data, registered, upper byte always 0
wb_ack_o  out  1  cycle acknowledge
irq_i  in  NUM_IRQ  asynchronous active-high requests (e.g. ~p_irq_b of the tube)
nmi_i  in  1  asynchronous active-high NMI request
intr_o  out  1  maskable interrupt request to CPU
inta_i  in  1  CPU interrupt acknowledge (level, held for the INTA bus cycle)
nmi_o  out  1  NMI request to CPU
nmia_i  in  1  CPU NMI acknowledge (level)
vec_o  out  8  vector: NMI_VEC while nmia_i is high, else the latched channel vector while inta_i is high, else 0

Behaviour:
- Reset (rst high at a clk edge): all sync stages, PEND, ISR, latched vector, wb_ack_o, wb_dat_o, intr_o and nmi_o are 0. MASK resets to all 1s; MODE resets to all 0 (edge).
- Reset mid-operation aborts any INTA in progress and drops every pending or in-service state. While rst is high, no Wishbone ack is issued.
- Synchronisers: each irq_i bit and nmi_i pass through SYNC_STAGES flops. An edge is detected as sync_out & ~prev, giving a latency of SYNC_STAGES+1 cycles from the input to the PEND bit.
- Wishbone slave:
  - wb_ack_o <= wb_stb_i & wb_cyc_i & ~wb_ack_o, i.e. one cycle of latency and exactly one ack per access.
  - Writes take effect on the cycle ack is raised; read data is valid with ack.
- Registers (index = wb_adr_i):
  - 0 EOI (W): dat[7]=1 clears the highest-priority ISR bit (non-specific EOI). dat[7]=0 clears ISR bit dat[2:0]. An index >= NUM_IRQ, or an EOI with ISR=0, is ignored. Reads return 0.
  - 1 MASK (R/W): 1 = channel masked.
  - 2 MODE (R/W): 1 = level mode.
  - 3 PEND (R): pending bits.
  - 4 ISR (R): in-service bits.
  - 5 STATUS (R): bit0=intr_o, bit1=nmi_o, bits[6:4]=current highest-priority eligible channel.
  - 6-7: reads return 0, writes are ignored.
  - Bits at or above NUM_IRQ read as 0.
- PEND:
  - Edge mode: set by a synced rising edge; cleared when the channel is acknowledged.
  - Level mode: PEND equals the synced level; it is not cleared by acknowledge.
  - If a set and an acknowledge-clear of the same bit occur in the same cycle, the set wins.
- Eligibility: a channel n is eligible when PEND[n] & ~MASK[n] and no ISR bit with index <= n is set (fully nested).
- intr_o is registered: intr_o <= any eligible channel & ~inta_busy. It falls one cycle after inta_i rises.
- INTA state machine:
  - IDLE -> ACK on inta_i rising edge. On that edge, latch the highest-priority eligible channel k: vec <= VEC_BASE+k, set ISR[k], clear PEND[k] in edge mode.
  - If no channel is eligible at the INTA edge (spurious), the latch is VEC_BASE+7 and ISR/PEND are unchanged.
  - ACK -> IDLE when inta_i falls. inta_busy = (state == ACK).
- NMI: nmi_o is set on a synced nmi_i rising edge and cleared on the rising edge of nmia_i. A new edge in the same cycle as that clear keeps nmi_o set. NMI does not interact with ISR/PEND.
- vec_o is combinational from nmia_i, inta_i and the latched vector. nmia_i takes precedence if both are high.

Test Plan:
- Reset, then read MASK/MODE/PEND/ISR -> 0x000F/0x0000/0x0000/0x0000; intr_o=0, nmi_o=0; each read acks exactly 1 cycle after stb.
- Write MASK=0x00; pulse irq_i[2] -> PEND=0x04 and intr_o=1 within SYNC_STAGES+2 cycles. Raise inta_i -> vec_o=0x0E, intr_o=0 the next cycle, ISR=0x04, PEND=0x00.
- With ISR[2] set, pulse irq_i[3] -> intr_o stays 0. Pulse irq_i[1] -> intr_o=1 and INTA gives vec_o=0x0D, ISR=0x06. Write EOI 0x80 -> ISR=0x04; the next EOI 0x80 -> ISR=0x00, and intr_o=1 for the still-pending channel 3.
- MODE=0x01, hold irq_i[0] high, perform INTA then EOI 0x00 -> intr_o reasserts (level persists). Drop irq_i[0] -> PEND[0]=0 and intr_o=0.
- Pulse nmi_i -> nmi_o=1. Raise nmia_i -> vec_o=0x02 and nmi_o=0 the next cycle. Pulse nmi_i in the same cycle that nmia_i rises -> nmi_o remains 1.
- Assert rst during an INTA with ISR=0x01 and PEND=0x02 -> all state 0, MASK=0x0F, no ack while rst is high.
